dem_gio_phut_giay: RTL and testbench
====================================

// Module: dem_gio_phut_giay
// PURPOSE
//  Time-of-day counter downstream of the 1 Hz clock divider. Synchronises the divider's
//  slow square wave (xung_1hz), detects its rising edge and advances a BCD HH:MM:SS value
//  once per edge. Drives the 7-segment display scan stage. Supports a time-set load.
// PARAMETERS
//  SYNC_STAGES  2  flip-flops in the xung_1hz synchroniser chain; legal range 2..3
//  H24          1  1 = 24-hour mode, hours 00..23; 0 = 12-hour mode, hours 01..12 plus pm flag
// PORTS
//  clk       in   1  system clock, 50 MHz; all logic on its rising edge
//  rst       in   1  synchronous, active-high reset
//  xung_1hz  in   1  square wave from the divider, one rising edge per second
//  en        in   1  count enable; 1 = advance on each detected edge
//  load      in   1  one-cycle strobe: load load_hh/load_mm/load_ss/load_pm
//  load_hh   in   8  BCD hours to load, tens in [7:4], units in [3:0]
//  load_mm   in   8  BCD minutes to load
//  load_ss   in   8  BCD seconds to load
//  load_pm   in   1  pm flag to load; ignored when H24=1
//  hh        out  8  current hours, BCD
//  mm        out  8  current minutes, BCD
//  ss        out  8  current seconds, BCD
//  pm        out  1  pm flag in 12-hour mode; constant 0 when H24=1
//  tick_1s   out  1  one-cycle pulse in the cycle hh/mm/ss advance
//  rollover  out  1  one-cycle pulse on the day wrap; coincides with tick_1s
//  load_err  out  1  one-cycle pulse when a load was rejected
// BEHAVIOUR
//  - Reset: hh/mm/ss = 00:00:00 when H24=1; 12:00:00 with pm=0 when H24=0.
//  - Reset: tick_1s, rollover and load_err = 0. Synchroniser chain and edge register cleared.
//  - Edge detection: xung_1hz passes through SYNC_STAGES flops, then an edge register.
//  - An edge is detected when the last synchroniser flop = 1 and the edge register = 0.
//  - Detection is masked for the first SYNC_STAGES+1 cycles after rst deasserts.
//    An input already high at reset release therefore produces no tick.
//  - Latency: with xung_1hz sampled high at clock edge k, the time registers and tick_1s
//    update at edge k+SYNC_STAGES. Exactly one advance per input rising edge.
//  - Falling edges and a held-high input produce no ticks.
//  - Advance, applied only when en=1 and the edge is detected:
//    - ss units 0..9 carry into ss tens 0..5; 59 wraps to 00 with a carry into mm.
//    - mm counts and carries the same way into hh.
//    - H24=1: 23:59:59 -> 00:00:00 and rollover=1.
//    - H24=0: 11:59:59 -> 12:00:00 with pm toggled; rollover=1 only when pm goes 1->0.
//    - H24=0: 12:59:59 -> 01:00:00 with pm unchanged; hour 12 is followed by 01.
//  - en=0: detected edges are discarded, not queued. tick_1s stays 0 and the time holds.
//  - Load, in the same cycle as the strobe:
//    - Valid load: outputs take the loaded values at the next edge of clk.
//    - Valid requires every BCD digit <= 9, ss <= 59, mm <= 59, and hh 00..23 (H24=1)
//      or 01..12 (H24=0).
//    - Invalid load: time unchanged and load_err=1 for one cycle.
//  - Simultaneous load and tick: load wins and the tick is dropped.
//    tick_1s=0 and rollover=0 in that cycle, including when the load is invalid.
//  - load is honoured regardless of en.
//  - rst has priority over everything. Reset mid-count returns to the reset value on the next
//    edge; any edge in flight in the synchroniser is lost.
//  - All outputs are registered; no combinational input-to-output path.
// TESTING
//  1. rst 3 cycles with xung_1hz=1 held -> no tick_1s, time 00:00:00; first 0->1 edge gives 00:00:01.
//  2. en=1, 60 input edges from 00:00:00 -> 00:01:00, exactly 60 tick_1s pulses.
//     Latency is SYNC_STAGES cycles from the sampled edge.
//  3. load 23:59:58, 2 edges -> 23:59:59, then 00:00:00 with rollover=1 for one cycle;
//     with H24=0, load 11:59:59 pm=1 plus 1 edge -> 12:00:00, pm=0, rollover=1.
//  4. load 24:00:00, then 12:5A:00 -> load_err pulse for each, time unchanged;
//     H24=0, load 00:10:00 -> load_err.
//  5. load 08:30:00 in the same cycle as a detected edge -> 08:30:00, tick_1s=0;
//     en=0 over 5 edges -> time held, then en=1 with 1 edge -> +1 s only.
//  6. rst asserted mid-count at 05:43:21 -> 00:00:00 next cycle; no residual tick after release.

Source files
------------

// File: rtl/dem_gio_phut_giay.sv
// rtl/dem_gio_phut_giay.sv - BCD HH:MM:SS time-of-day counter advanced by a synchronised 1 Hz edge
`timescale 1ns/1ps
module dem_gio_phut_giay #(
  parameter int SYNC_STAGES = 2,
  parameter bit H24         = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       xung_1hz,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  input  logic       load_pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick_1s,
  output logic       rollover,
  output logic       load_err
);

  localparam int            MW       = $clog2(SYNC_STAGES + 2);
  localparam logic [MW-1:0] MASK_END = MW'(SYNC_STAGES + 1);
  localparam logic [7:0]    HH_RST   = H24 ? 8'h00 : 8'h12;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic [MW-1:0]          mask_cnt;
  logic                   edge_det;
  logic                   load_ok;
  logic [7:0]             hh_nx, mm_nx, ss_nx;
  logic                   pm_nx, wrap_nx;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Mask covers the cycles where the edge register still holds its reset 0.
  assign edge_det = (mask_cnt == MASK_END) && sync_q[SYNC_STAGES-1] && !edge_q;

  // With every digit valid, binary compares order BCD values correctly.
  always_comb begin
    load_ok = bcd_ok(load_hh) && bcd_ok(load_mm) && bcd_ok(load_ss)
              && (load_mm <= 8'h59) && (load_ss <= 8'h59);
    if (H24) begin
      load_ok = load_ok && (load_hh <= 8'h23);
    end else begin
      load_ok = load_ok && (load_hh >= 8'h01) && (load_hh <= 8'h12);
    end
  end

  always_comb begin
    ss_nx   = bcd_inc(ss);
    mm_nx   = mm;
    hh_nx   = hh;
    pm_nx   = pm;
    wrap_nx = 1'b0;
    if (ss == 8'h59) begin
      ss_nx = 8'h00;
      mm_nx = bcd_inc(mm);
      if (mm == 8'h59) begin
        mm_nx = 8'h00;
        if (H24) begin
          if (hh == 8'h23) begin
            hh_nx   = 8'h00;
            wrap_nx = 1'b1;
          end else begin
            hh_nx = bcd_inc(hh);
          end
        end else if (hh == 8'h11) begin
          // Midnight is the pm -> am change at 12 o'clock.
          hh_nx   = 8'h12;
          pm_nx   = ~pm;
          wrap_nx = pm;
        end else if (hh == 8'h12) begin
          hh_nx = 8'h01;
        end else begin
          hh_nx = bcd_inc(hh);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      mask_cnt <= '0;
      hh       <= HH_RST;
      mm       <= 8'h00;
      ss       <= 8'h00;
      pm       <= 1'b0;
      tick_1s  <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], xung_1hz};
      edge_q   <= sync_q[SYNC_STAGES-1];
      if (mask_cnt != MASK_END) mask_cnt <= mask_cnt + MW'(1);
      tick_1s  <= 1'b0;
      rollover <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          hh <= load_hh;
          mm <= load_mm;
          ss <= load_ss;
          pm <= H24 ? 1'b0 : load_pm;
        end else begin
          load_err <= 1'b1;
        end
      end else if (en && edge_det) begin
        hh       <= hh_nx;
        mm       <= mm_nx;
        ss       <= ss_nx;
        pm       <= pm_nx;
        tick_1s  <= 1'b1;
        rollover <= wrap_nx;
      end
    end
  end

endmodule

// File: tb/tb_dem_gio_phut_giay.sv
// tb/tb_dem_gio_phut_giay.sv - directed and random bench for dem_gio_phut_giay, 24h and 12h instances
`timescale 1ns/1ps
module tb_dem_gio_phut_giay;

  logic       clk = 1'b0;
  logic       rst, x, en, load, load_pm;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [7:0] hh_a, mm_a, ss_a, hh_b, mm_b, ss_b;
  logic       pm_a, tick_a, roll_a, err_a, pm_b, tick_b, roll_b, err_b;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int ticks_a, ticks_b, rolls_a, rolls_b, errs_a, errs_b;

  // Reference state: seconds since midnight; both display modes derive from it.
  int sec_a, sec_b;
  bit et_a, er_a, ee_a, et_b, er_b, ee_b;
  // Last three sampled input levels; pre-filled high after reset so a level
  // already present at release is not taken as a new edge.
  int hist[$] = '{1, 1, 1};

  always #10 clk = ~clk;

  dem_gio_phut_giay #(.SYNC_STAGES(2), .H24(1'b1)) u_a (
    .clk(clk), .rst(rst), .xung_1hz(x), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_a), .mm(mm_a), .ss(ss_a), .pm(pm_a),
    .tick_1s(tick_a), .rollover(roll_a), .load_err(err_a)
  );

  dem_gio_phut_giay #(.SYNC_STAGES(2), .H24(1'b0)) u_b (
    .clk(clk), .rst(rst), .xung_1hz(x), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
    .hh(hh_b), .mm(mm_b), .ss(ss_b), .pm(pm_b),
    .tick_1s(tick_b), .rollover(roll_b), .load_err(err_b)
  );

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic logic [26:0] expv(input int s, input bit h24, input bit t, input bit r, input bit e);
    int h;
    bit p;
    h = s / 3600;
    p = 1'b0;
    if (!h24) begin
      p = (h >= 12);
      h = h % 12;
      if (h == 0) h = 12;
    end
    return {bcd2(h), bcd2((s / 60) % 60), bcd2(s % 60), p, t, r, e};
  endfunction

  function automatic int load_sec(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                  input logic p, input bit h24);
    int hv, mv, sv;
    if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 || s[7:4] > 9 || s[3:0] > 9)
      return -1;
    hv = int'(h[7:4]) * 10 + int'(h[3:0]);
    mv = int'(m[7:4]) * 10 + int'(m[3:0]);
    sv = int'(s[7:4]) * 10 + int'(s[3:0]);
    if (mv > 59 || sv > 59) return -1;
    if (h24) begin
      if (hv > 23) return -1;
      return hv * 3600 + mv * 60 + sv;
    end
    if (hv < 1 || hv > 12) return -1;
    return ((hv % 12) + (p ? 12 : 0)) * 3600 + mv * 60 + sv;
  endfunction

  task automatic adv(inout int s, input bit h24, input bit rise, output bit t, output bit r, output bit e);
    int ls;
    t = 1'b0; r = 1'b0; e = 1'b0;
    if (load) begin
      ls = load_sec(load_hh, load_mm, load_ss, load_pm, h24);
      if (ls < 0) e = 1'b1;
      else s = ls;
    end else if (en && rise) begin
      t = 1'b1;
      if (s == 86399) begin
        s = 0;
        r = 1'b1;
      end else begin
        s++;
      end
    end
  endtask

  task automatic model_edge();
    bit rise;
    if (rst) begin
      sec_a = 0; sec_b = 0;
      et_a = 0; er_a = 0; ee_a = 0; et_b = 0; er_b = 0; ee_b = 0;
      hist = '{1, 1, 1};
      return;
    end
    // A level sampled at edge n acts at edge n+2.
    rise = (hist[1] == 1) && (hist[0] == 0);
    hist.push_back(int'(x));
    void'(hist.pop_front());
    adv(sec_a, 1'b1, rise, et_a, er_a, ee_a);
    adv(sec_b, 1'b0, rise, et_b, er_b, ee_b);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("cycle_a", 64'({hh_a, mm_a, ss_a, pm_a, tick_a, roll_a, err_a}), 64'(expv(sec_a, 1'b1, et_a, er_a, ee_a)));
    chk("cycle_b", 64'({hh_b, mm_b, ss_b, pm_b, tick_b, roll_b, err_b}), 64'(expv(sec_b, 1'b0, et_b, er_b, ee_b)));
    ticks_a += int'(tick_a); ticks_b += int'(tick_b);
    rolls_a += int'(roll_a); rolls_b += int'(roll_b);
    errs_a  += int'(err_a);  errs_b  += int'(err_b);
  endtask

  task automatic clr();
    ticks_a = 0; ticks_b = 0; rolls_a = 0; rolls_b = 0; errs_a = 0; errs_b = 0;
  endtask

  task automatic pulse();
    x = 1'b0;
    repeat (3) cyc();
    x = 1'b1;
    repeat (3) cyc();
  endtask

  task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic p);
    load = 1'b1; load_hh = h; load_mm = m; load_ss = s; load_pm = p;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; x = 1'b1; en = 1'b1; load = 1'b0;
    load_hh = 8'h00; load_mm = 8'h00; load_ss = 8'h00; load_pm = 1'b0;
    clr();

    repeat (3) cyc();
    chk("reset_a", 64'({hh_a, mm_a, ss_a, tick_a, roll_a, err_a}), 64'({24'h000000, 3'b000}));
    chk("reset_b", 64'({hh_b, mm_b, ss_b, pm_b}), 64'({24'h120000, 1'b0}));
    rst = 1'b0;
    clr();
    repeat (8) cyc();
    chk("held_high_no_tick", 64'(ticks_a + ticks_b), 64'd0);
    pulse();
    chk("first_edge_a", 64'({hh_a, mm_a, ss_a}), 64'h000001);

    do_load(8'h00, 8'h00, 8'h00, 1'b0);
    clr();
    x = 1'b0;
    repeat (2) cyc();
    x = 1'b1;
    cyc();
    chk("latency_k", 64'(tick_a), 64'd0);
    cyc();
    chk("latency_k1", 64'(tick_a), 64'd0);
    cyc();
    chk("latency_k2", 64'(tick_a), 64'd1);
    repeat (59) pulse();
    chk("sixty_ticks_a", 64'(ticks_a), 64'd60);
    chk("one_minute_a", 64'({hh_a, mm_a, ss_a}), 64'h000100);
    chk("one_minute_b", 64'({hh_b, mm_b, ss_b}), 64'h120101);

    clr();
    do_load(8'h23, 8'h59, 8'h58, 1'b0);
    pulse();
    pulse();
    chk("day_wrap_a", 64'({hh_a, mm_a, ss_a}), 64'h000000);
    chk("rollover_count_a", 64'(rolls_a), 64'd1);
    clr();
    do_load(8'h11, 8'h59, 8'h59, 1'b1);
    pulse();
    chk("midnight_b", 64'({hh_b, mm_b, ss_b, pm_b}), 64'({24'h120000, 1'b0}));
    chk("rollover_count_b", 64'(rolls_b), 64'd1);
    chk("noon_no_roll_a", 64'(rolls_a), 64'd0);
    do_load(8'h12, 8'h59, 8'h59, 1'b1);
    pulse();
    chk("twelve_to_one_b", 64'({hh_b, mm_b, ss_b, pm_b}), 64'({24'h010000, 1'b1}));

    clr();
    do_load(8'h24, 8'h00, 8'h00, 1'b0);
    do_load(8'h12, 8'h5A, 8'h00, 1'b0);
    do_load(8'h00, 8'h10, 8'h00, 1'b0);
    chk("load_err_count_a", 64'(errs_a), 64'd2);
    chk("load_err_count_b", 64'(errs_b), 64'd3);
    chk("after_err_a", 64'({hh_a, mm_a, ss_a}), 64'h001000);
    chk("after_err_b", 64'({hh_b, mm_b, ss_b, pm_b}), 64'({24'h010000, 1'b1}));

    x = 1'b0;
    repeat (2) cyc();
    x = 1'b1;
    cyc();
    cyc();
    do_load(8'h08, 8'h30, 8'h00, 1'b0);
    chk("load_beats_tick", 64'({tick_a, tick_b, hh_a, mm_a, ss_a}), 64'({2'b00, 24'h083000}));
    en = 1'b0;
    clr();
    repeat (5) pulse();
    chk("en0_ticks", 64'(ticks_a + ticks_b), 64'd0);
    chk("en0_hold_a", 64'({hh_a, mm_a, ss_a}), 64'h083000);
    en = 1'b1;
    pulse();
    chk("en1_plus_one_a", 64'({hh_a, mm_a, ss_a}), 64'h083001);

    x = 1'b0;
    repeat (2) cyc();
    do_load(8'h05, 8'h43, 8'h21, 1'b0);
    x = 1'b1;
    cyc();
    rst = 1'b1;
    cyc();
    chk("midreset_a", 64'({hh_a, mm_a, ss_a}), 64'h000000);
    chk("midreset_b", 64'({hh_b, mm_b, ss_b, pm_b}), 64'({24'h120000, 1'b0}));
    rst = 1'b0;
    clr();
    repeat (8) cyc();
    chk("no_residual_tick", 64'(ticks_a + ticks_b), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) x = ~x;
      en   = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 399) == 0);
      load = ($urandom_range(0, 29) == 0);
      if (load) begin
        case ($urandom_range(0, 3))
          0:       load_hh = 8'h23;
          1:       load_hh = 8'h11;
          2:       load_hh = 8'h12;
          default: load_hh = 8'($urandom_range(0, 255));
        endcase
        load_mm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h59;
        load_ss = bcd2(int'($urandom_range(50, 59)));
        load_pm = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    rst = 1'b0;
    load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
